// File: rtl/combat_status_ctrl_pkg.sv
// combat_pkg: scene codes, fight states, default damage/HP constants and phase helper.
package combat_pkg;
  typedef enum logic [1:0] {SCN_OPEN = 2'b00, SCN_GAME = 2'b01, SCN_WIN = 2'b10, SCN_LOSE = 2'b11} scene_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FIGHT, ST_INVULN, ST_OVER} state_e;
  localparam logic [9:0] DEF_BOSS_HP_MAX  = 10'd500;
  localparam logic [1:0] DEF_PLAYER_LIVES = 2'd3;
  localparam logic [9:0] DEF_DMG_NORMAL   = 10'd1;
  localparam logic [9:0] DEF_DMG_CHARGED  = 10'd5;
  localparam logic [7:0] DEF_INVULN_TICKS = 8'd24;
  localparam logic [9:0] DEF_PHASE1_HP    = 10'd300;
  localparam logic [9:0] DEF_PHASE2_HP    = 10'd150;
  function automatic logic [1:0] phase_of(input logic [9:0] hp, input logic [9:0] p1, input logic [9:0] p2);
    return hp == '0 ? 2'd3 : hp < p2 ? 2'd2 : hp < p1 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/combat_status_ctrl_if.sv
// combat_status_ctrl_if: hit events and scene in, HP/life/phase status out.
interface combat_status_ctrl_if;
  import combat_pkg::*;
  logic       gamestart;
  scene_e     scene;
  logic       boss_hit;
  logic       boss_hit_charged;
  logic       player_hit;
  logic [9:0] bosshp;
  logic [1:0] life;
  logic       invuln;
  logic [1:0] phase;
  logic       hit_flash;
  modport master (output gamestart, scene, boss_hit, boss_hit_charged, player_hit,
                  input bosshp, life, invuln, phase, hit_flash);
  modport slave  (input gamestart, scene, boss_hit, boss_hit_charged, player_hit,
                  output bosshp, life, invuln, phase, hit_flash);
endinterface

// File: rtl/combat_status_ctrl_tick_countdown.sv
// tick_countdown: loadable down-counter that stops at zero and flags it.
module tick_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/combat_status_ctrl.sv
// combat_status_ctrl: boss HP / player life bookkeeping with invulnerability and boss phase.
// Define BOSS_REGEN_EN to let the boss regain 1 HP every REGEN_PERIOD damage-free fight cycles.
module combat_status_ctrl
  import combat_pkg::*;
#(
  parameter logic [9:0] BOSS_HP_MAX  = DEF_BOSS_HP_MAX,
  parameter logic [1:0] PLAYER_LIVES = DEF_PLAYER_LIVES,
  parameter logic [9:0] DMG_NORMAL   = DEF_DMG_NORMAL,
  parameter logic [9:0] DMG_CHARGED  = DEF_DMG_CHARGED,
  parameter logic [7:0] INVULN_TICKS = DEF_INVULN_TICKS,
`ifdef BOSS_REGEN_EN
  parameter logic [7:0] REGEN_PERIOD = 8'd48,
`endif
  parameter logic [9:0] PHASE1_HP    = DEF_PHASE1_HP,
  parameter logic [9:0] PHASE2_HP    = DEF_PHASE2_HP
) (
  input  logic                 clk_22,
  input  logic                 rst_n,
  combat_status_ctrl_if.slave  bus
);
  state_e     state_q, state_d;
  logic [9:0] hp_q, hp_d, dmg, hp_hit, hp_nx;
  logic [1:0] life_q, life_d, life_dec, phase_q, phase_d;
  logic       invuln_q, invuln_d, flash_q, flash_d;
  logic       active, p_hit, inv_zero, regen_tick;
  always_comb begin
    active   = state_q == ST_FIGHT || state_q == ST_INVULN;
    dmg      = bus.boss_hit_charged ? DMG_CHARGED : bus.boss_hit ? DMG_NORMAL : '0;
    hp_hit   = hp_q > dmg ? hp_q - dmg : '0;
    hp_nx    = regen_tick && hp_hit < BOSS_HP_MAX ? hp_hit + 10'd1 : hp_hit;
    // a boss kill this cycle wins over a simultaneous player hit
    p_hit    = state_q == ST_FIGHT && bus.player_hit && hp_nx != '0 && life_q != '0;
    life_dec = p_hit ? life_q - 2'd1 : life_q;
  end
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    life_d  = life_q;
    flash_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hp_d    = BOSS_HP_MAX;
        life_d  = PLAYER_LIVES;
        state_d = bus.gamestart ? ST_FIGHT : ST_IDLE;
      end
      ST_FIGHT, ST_INVULN: begin
        hp_d    = hp_nx;
        life_d  = life_dec;
        flash_d = dmg != '0 && hp_q != '0;
        state_d = hp_nx == '0 || life_dec == '0 ? ST_OVER :
                  p_hit ? ST_INVULN :
                  state_q == ST_INVULN && inv_zero ? ST_FIGHT : state_q;
      end
      ST_OVER: if (bus.scene == SCN_OPEN) begin
        state_d = ST_IDLE;
        hp_d    = BOSS_HP_MAX;
        life_d  = PLAYER_LIVES;
      end
      default: state_d = ST_IDLE;
    endcase
    phase_d  = phase_of(hp_d, PHASE1_HP, PHASE2_HP);
    invuln_d = state_d == ST_INVULN;
  end
  tick_countdown #(.W(8)) u_invuln (
    .clk(clk_22), .rst_n(rst_n),
    .load_i(state_q == ST_FIGHT && state_d == ST_INVULN),
    .en_i(state_q == ST_INVULN),
    .val_i(INVULN_TICKS - 8'd1),
    .zero_o(inv_zero)
  );
`ifdef BOSS_REGEN_EN
  logic regen_zero;
  // held at PERIOD-1 outside the fight so the first fight cycle starts a full period
  tick_countdown #(.W(8)) u_regen (
    .clk(clk_22), .rst_n(rst_n),
    .load_i(!active || dmg != '0 || regen_zero),
    .en_i(active),
    .val_i(REGEN_PERIOD - 8'd1),
    .zero_o(regen_zero)
  );
  assign regen_tick = active && dmg == '0 && regen_zero;
`else
  assign regen_tick = 1'b0;
`endif
  always_ff @(posedge clk_22 or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hp_q     <= BOSS_HP_MAX;
      life_q   <= PLAYER_LIVES;
      phase_q  <= '0;
      invuln_q <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      life_q   <= life_d;
      phase_q  <= phase_d;
      invuln_q <= invuln_d;
      flash_q  <= flash_d;
    end
  assign bus.bosshp    = hp_q;
  assign bus.life      = life_q;
  assign bus.phase     = phase_q;
  assign bus.invuln    = invuln_q;
  assign bus.hit_flash = flash_q;
endmodule

// File: tb/tb_combat_status_ctrl.sv
// tb_combat_status_ctrl: directed and random hit sequences checked against a cycle-level fight model.
module tb_combat_status_ctrl;
  import combat_pkg::*;
  localparam int HPMAX = 500, LIVES = 3, INV = 24, REGEN = 48;
  logic clk_22 = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  int m_hp, m_life, m_inv, m_stage, m_regen;
  bit m_flash;
  combat_status_ctrl_if bus ();
  combat_status_ctrl dut (.clk_22(clk_22), .rst_n(rst_n), .bus(bus));
  always #5 clk_22 = ~clk_22;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_hp = HPMAX; m_life = LIVES; m_inv = 0; m_stage = 0; m_regen = 0; m_flash = 0;
  endfunction

  // stage: 0 waiting for start, 1 fighting, 2 decided
  function automatic void m_step(bit gs, bit [1:0] sc, bit bh, bit bc, bit ph);
    int d, nhp;
    bit was_inv;
    m_flash = 0;
    if (m_stage == 0) begin
      m_hp = HPMAX; m_life = LIVES;
      if (gs) m_stage = 1;
    end else if (m_stage == 2) begin
      if (sc == 2'b00) begin m_stage = 0; m_hp = HPMAX; m_life = LIVES; end
    end else begin
      d = bc ? 5 : bh ? 1 : 0;
      nhp = m_hp - d < 0 ? 0 : m_hp - d;
      m_flash = d > 0 && m_hp > 0;
`ifdef BOSS_REGEN_EN
      if (d > 0) m_regen = 0;
      else begin
        m_regen++;
        if (m_regen == REGEN) begin m_regen = 0; if (nhp < HPMAX) nhp++; end
      end
`endif
      was_inv = m_inv > 0;
      if (was_inv) m_inv--;
      if (!was_inv && ph && nhp > 0) begin
        m_life--;
        if (m_life > 0) m_inv = INV;
      end
      m_hp = nhp;
      if (m_hp == 0 || m_life == 0) begin m_stage = 2; m_inv = 0; end
    end
    if (m_stage != 1) m_regen = 0;
  endfunction

  task automatic check_all();
    chk("bosshp", bus.bosshp, m_hp);
    chk("life", bus.life, m_life);
    chk("invuln", bus.invuln, m_stage == 1 && m_inv > 0);
    chk("phase", bus.phase, m_hp == 0 ? 3 : m_hp < 150 ? 2 : m_hp < 300 ? 1 : 0);
    chk("hit_flash", bus.hit_flash, m_flash);
  endtask

  task automatic cyc(bit gs, bit [1:0] sc, bit bh, bit bc, bit ph);
    bus.gamestart = gs; bus.scene = scene_e'(sc);
    bus.boss_hit = bh; bus.boss_hit_charged = bc; bus.player_hit = ph;
    m_step(gs, sc, bh, bc, ph);
    @(posedge clk_22); #1;
    check_all();
  endtask

  task automatic restart();
    bus.gamestart = 0; bus.boss_hit = 0; bus.boss_hit_charged = 0; bus.player_hit = 0;
    rst_n = 0;
    m_reset();
    #2;
    check_all();
    chk("rst_hp", bus.bosshp, HPMAX);
    chk("rst_life", bus.life, LIVES);
    rst_n = 1;
    cyc(1, SCN_GAME, 0, 0, 0);
  endtask

  task automatic prep(int hp_t, int life_t);
    restart();
    while (m_life > life_t) begin
      cyc(0, SCN_GAME, 0, 0, 1);
      repeat (INV) cyc(0, SCN_GAME, 0, 0, 0);
    end
    while (m_hp - 5 >= hp_t) cyc(0, SCN_GAME, 0, 1, 0);
    while (m_hp > hp_t) cyc(0, SCN_GAME, 1, 0, 0);
  endtask

  initial begin
    bus.gamestart = 0; bus.scene = SCN_OPEN;
    bus.boss_hit = 0; bus.boss_hit_charged = 0; bus.player_hit = 0;
    m_reset();
    #12;
    check_all();
    rst_n = 1;
    repeat (3) cyc(0, SCN_OPEN, 1'($urandom), 1'($urandom), 1'($urandom));
    cyc(1, SCN_GAME, 0, 0, 0);
    chk("start_hp", bus.bosshp, 500);
    chk("start_life", bus.life, 3);
    chk("start_phase", bus.phase, 0);
    repeat (200) cyc(0, SCN_GAME, 1, 0, 0);
    chk("hp300", bus.bosshp, 300);
    chk("phase0_at300", bus.phase, 0);
    cyc(0, SCN_GAME, 1, 0, 0);
    chk("hp299", bus.bosshp, 299);
    chk("phase1_at299", bus.phase, 1);
    cyc(0, SCN_GAME, 0, 0, 0);
    chk("flash_drop", bus.hit_flash, 0);
    cyc(0, SCN_GAME, 0, 0, 1);
    chk("life2", bus.life, 2);
    chk("invuln_on", bus.invuln, 1);
    repeat (INV) cyc(0, SCN_GAME, 1'($urandom), 0, 1);
    chk("life_kept2", bus.life, 2);
    cyc(0, SCN_GAME, 0, 0, 1);
    chk("life1", bus.life, 1);
    repeat (5) cyc(0, SCN_GAME, 0, 0, 0);
    chk("mid_invuln", bus.invuln, 1);
    restart();
    prep(3, 3);
    cyc(0, SCN_GAME, 1, 1, 0);
    chk("kill_hp0", bus.bosshp, 0);
    chk("kill_phase3", bus.phase, 3);
    repeat (4) cyc(1'($urandom), SCN_WIN, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("over_frozen", bus.bosshp, 0);
    cyc(0, SCN_OPEN, 0, 0, 0);
    chk("reload_hp", bus.bosshp, 500);
    chk("reload_life", bus.life, 3);
    prep(1, 1);
    cyc(0, SCN_GAME, 1, 0, 1);
    chk("win_hp", bus.bosshp, 0);
    chk("win_life", bus.life, 1);
    prep(10, 1);
    cyc(0, SCN_GAME, 1, 0, 1);
    chk("lose_hp", bus.bosshp, 9);
    chk("lose_life", bus.life, 0);
    cyc(0, SCN_GAME, 1, 1, 0);
    chk("lose_frozen", bus.bosshp, 9);
`ifdef BOSS_REGEN_EN
    prep(400, 3);
    repeat (REGEN - 1) cyc(0, SCN_GAME, 0, 0, 0);
    chk("regen_wait", bus.bosshp, 400);
    cyc(0, SCN_GAME, 0, 0, 0);
    chk("regen_step", bus.bosshp, 401);
`endif
    restart();
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit [1:0] sc;
      r = $urandom_range(0, 9);
      sc = r < 7 ? 2'b01 : r == 7 ? 2'b00 : r == 8 ? 2'b10 : 2'b11;
      cyc($urandom_range(0, 19) == 0, sc, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/combat_status_ctrl.md
Name: combat_status_ctrl

Overview:
- Owns the boss HP and player life registers that the scene controller reads as its win/lose inputs.
- Converts hit events into bounded HP/life updates; applies post-hit invulnerability; reports a boss phase for the attack-pattern logic.
- Reloads on game start and freezes once the fight is decided.
- Sits between the collision detectors and the scene controller, in the clk_22 domain.

Parameters:
- BOSS_HP_MAX, 10'd500, boss HP loaded at start; must be 1..1023.
- PLAYER_LIVES, 2'd3, lives loaded at start; must be 1..3.
- DMG_NORMAL, 10'd1, HP removed by a normal hit.
- DMG_CHARGED, 10'd5, HP removed by a charged hit.
- INVULN_TICKS, 8'd24, clk_22 cycles of invulnerability after a player hit; must be ≥1.
- PHASE1_HP, 10'd300, HP below which phase becomes 1.
- PHASE2_HP, 10'd150, HP below which phase becomes 2; must be < PHASE1_HP.
- REGEN_PERIOD, 8'd48, cycles per regen step (used only with the optional feature).

Ports:
- clk_22  in  1  game tick clock.
- rst_n  in  1  asynchronous reset, active low.
- gamestart  in  1  one-cycle pulse from the scene controller.
- scene  in  2  current scene: 00 open, 01 game, 10 win, 11 lose.
- boss_hit  in  1  normal player bullet hit the boss this cycle.
- boss_hit_charged  in  1  charged bullet hit the boss this cycle.
- player_hit  in  1  boss bullet or contact hit the player this cycle.
- bosshp  out  10  boss HP, registered.
- life  out  2  player lives, registered.
- invuln  out  1  high while the player is invulnerable.
- phase  out  2  boss phase, registered.
- hit_flash  out  1  one-cycle pulse the cycle after boss damage is applied.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bosshp=BOSS_HP_MAX, life=PLAYER_LIVES, invuln=0, phase=0, hit_flash=0, all counters 0.
- States and transitions:
  - IDLE: bosshp and life held at their max values. All hit inputs ignored. gamestart=1 -> FIGHT.
  - FIGHT: boss damage and player hits are applied.
    - Player hit with resulting life>0 -> INVULN, counter=INVULN_TICKS-1.
    - Resulting bosshp==0 or life==0 -> OVER.
  - INVULN: invuln=1; player_hit ignored; boss damage still applied; counter decrements each cycle.
    - Counter==0 -> FIGHT on the same edge.
    - bosshp reaches 0 -> OVER.
  - OVER: all registers frozen; inputs ignored. scene==00 -> IDLE, which reloads HP and life on entry.
- Any state except IDLE: gamestart=1 is ignored.
- Boss damage:
  - Charged takes priority when both hit inputs are high; only DMG_CHARGED is applied.
  - Subtraction saturates at 0 (no wrap).
- Life decrement: by exactly 1, never below 0.
- Simultaneous boss kill and player hit: if boss damage drives bosshp to 0 in that cycle, the life decrement is suppressed. The boss-kill win therefore takes priority.
- phase, registered from the next bosshp value: 3 if 0; 2 if below PHASE2_HP; 1 if below PHASE1_HP; otherwise 0.
- hit_flash: 1 for exactly one cycle after each cycle in which a nonzero boss damage is applied. A hit on an HP of 0 gives no pulse.
- Latency: all outputs are registered, so an input takes effect on the next clk_22 edge.
- Handoff timing: IDLE holds nonzero HP/life, so the scene controller never sees a false win/lose in the first game-scene cycle.
- Reset mid-fight: immediate return to the reset values.

Optional Feature:
- BOSS_REGEN_EN defined:
  - In FIGHT/INVULN, a regen counter counts cycles without applied boss damage.
  - On reaching REGEN_PERIOD-1: bosshp+1, saturating at BOSS_HP_MAX; counter cleared.
  - Any applied boss damage clears the counter.
  - Regen never acts once bosshp==0.
- Not defined: no regen logic; REGEN_PERIOD unused.

Decomposition:
- Package combat_pkg:
  - Scene codes: SCN_OPEN, SCN_GAME, SCN_WIN, SCN_LOSE.
  - State enum: ST_IDLE, ST_FIGHT, ST_INVULN, ST_OVER.
  - Default damage and HP constants.
- Sub-module tick_countdown: loadable down-counter with load, enable and zero flag. Instanced for invulnerability and for regen.

Test Plan:
- Reset, then gamestart pulse -> state FIGHT; bosshp=500, life=3, phase=0 throughout the first cycle.
- 200 normal hits -> bosshp=300, phase=0. Next hit -> bosshp=299, phase=1. hit_flash pulses once per hit.
- bosshp=3 plus a charged hit (boss_hit also high) -> bosshp=0 (saturated), phase=3, state OVER.
- Inject player_hit -> life=2, invuln high for 24 cycles.
  - player_hit during that window -> life stays 2.
  - player_hit on cycle 25 -> life=1.
- Same-cycle hits:
  - bosshp=1, life=1, boss_hit and player_hit together -> bosshp=0, life=1 (win).
  - bosshp=10, life=1, same stimulus -> bosshp=9, life=0, state OVER.
- In OVER, set scene=00 -> state IDLE with bosshp=500, life=3.
  - With BOSS_REGEN_EN: 48 idle FIGHT cycles at bosshp=400 -> bosshp=401.
  - Assert rst_n=0 mid-INVULN -> all outputs return to reset values immediately.
